// File: rtl/mac_pkg.sv
// Shared Q-format constants, FSM encoding and helpers for the sequential MAC engine.
package mac_pkg;

   localparam int DATA_SIZE = 16;
   localparam int FRAC_BITS = 8;
   localparam int SAT_W     = 64;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_OUT   = 1'b1
   } state_t;

   typedef struct packed {
      logic [DATA_SIZE-1:0] data;
      logic                 clip;
   } sat_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   // Clamp a sign-extended accumulator into a dw-bit signed word and flag any clipping.
   function automatic sat_t sat_to_data(input logic signed [SAT_W-1:0] acc, input int dw);
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      logic signed [SAT_W-1:0] v;
      sat_t r;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = ~hi;
      if (acc > hi) begin
         v      = hi;
         r.clip = 1'b1;
      end else if (acc < lo) begin
         v      = lo;
         r.clip = 1'b1;
      end else begin
         v      = acc;
         r.clip = 1'b0;
      end
      r.data = DATA_SIZE'(v);
      return r;
   endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// Combinational lane stage: LANES fixed-point products, floored by FRAC_BITS,
// masked per lane and summed through a balanced adder tree.
module mac_lane_sum
   import mac_pkg::*;
#(
   parameter int DATA_SIZE = mac_pkg::DATA_SIZE,
   parameter int FRAC_BITS = mac_pkg::FRAC_BITS,
   parameter int LANES     = 5,
   parameter int ACC_SIZE  = 40
) (
   input  logic [DATA_SIZE*LANES-1:0] a,
   input  logic [DATA_SIZE*LANES-1:0] b,
   input  logic [LANES-1:0]           mask,
   output logic signed [ACC_SIZE-1:0] sum
);

   localparam int NP = 1 << clog2(LANES);

   // Heap-ordered tree: node 0 is the root, leaves start at NP-1.
   logic signed [ACC_SIZE-1:0] node [2*NP-1];

   genvar gi;
   generate
      for (gi = 0; gi < NP; gi++) begin : g_leaf
         if (gi < LANES) begin : g_lane
            logic signed [DATA_SIZE-1:0]   av;
            logic signed [DATA_SIZE-1:0]   bv;
            logic signed [2*DATA_SIZE-1:0] prod;
            assign av   = a[DATA_SIZE*(gi+1)-1 -: DATA_SIZE];
            assign bv   = b[DATA_SIZE*(gi+1)-1 -: DATA_SIZE];
            assign prod = av * bv;
            // Arithmetic shift floors toward -inf; the result fits in ACC_SIZE by construction.
            assign node[NP-1+gi] = mask[gi] ? ACC_SIZE'(prod >>> FRAC_BITS) : '0;
         end else begin : g_pad
            assign node[NP-1+gi] = '0;
         end
      end
      for (gi = 0; gi < NP-1; gi++) begin : g_tree
         assign node[gi] = node[2*gi+1] + node[2*gi+2];
      end
   endgenerate

   assign sum = node[0];

endmodule

// File: rtl/mac_accum_seq.sv
// Sequential multiply-accumulate: LANES products per beat, TAPS per window plus bias,
// one saturated result per window. Define RELU_EN to clamp negative results to zero.
module mac_accum_seq
   import mac_pkg::*;
#(
   parameter int DATA_SIZE = mac_pkg::DATA_SIZE,
   parameter int FRAC_BITS = mac_pkg::FRAC_BITS,
   parameter int TAPS      = 25,
   parameter int LANES     = 5,
   parameter int ACC_SIZE  = 40
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [DATA_SIZE*LANES-1:0] s_a,
   input  logic [DATA_SIZE*LANES-1:0] s_b,
   input  logic [DATA_SIZE-1:0]       s_bias,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [DATA_SIZE-1:0]       m_data,
   output logic                       m_sat
);

   localparam int             BEATS = (TAPS + LANES - 1) / LANES;
   localparam int             CW    = (BEATS > 1) ? clog2(BEATS) : 1;
   localparam logic [CW-1:0]  LAST  = CW'(BEATS - 1);

   state_t                     state_reg, state_next;
   logic [CW-1:0]              cnt_reg, cnt_next;
   logic signed [ACC_SIZE-1:0] acc_reg, acc_next;
   logic                       m_valid_reg, m_valid_next;
   logic [DATA_SIZE-1:0]       m_data_reg, m_data_next;
   logic                       m_sat_reg, m_sat_next;

   logic [LANES-1:0]           lane_mask;
   logic signed [ACC_SIZE-1:0] lane_sum;
   logic signed [ACC_SIZE-1:0] bias_ext;
   sat_t                       sat_res;

   // Lanes past the end of the window (last beat when TAPS is not a multiple of LANES).
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_mask
         assign lane_mask[gi] = (int'(cnt_reg) * LANES + gi) < TAPS;
      end
   endgenerate

   mac_lane_sum #(
      .DATA_SIZE (DATA_SIZE),
      .FRAC_BITS (FRAC_BITS),
      .LANES     (LANES),
      .ACC_SIZE  (ACC_SIZE)
   ) u_lane_sum (
      .a    (s_a),
      .b    (s_b),
      .mask (lane_mask),
      .sum  (lane_sum)
   );

   assign bias_ext = {{(ACC_SIZE-DATA_SIZE){s_bias[DATA_SIZE-1]}}, s_bias};
   assign sat_res  = sat_to_data({{(SAT_W-ACC_SIZE){acc_reg[ACC_SIZE-1]}}, acc_reg}, DATA_SIZE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= ST_ACCUM;
         cnt_reg     <= '0;
         acc_reg     <= '0;
         m_valid_reg <= 1'b0;
         m_data_reg  <= '0;
         m_sat_reg   <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         acc_reg     <= acc_next;
         m_valid_reg <= m_valid_next;
         m_data_reg  <= m_data_next;
         m_sat_reg   <= m_sat_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      acc_next     = acc_reg;
      m_valid_next = m_valid_reg;
      m_data_next  = m_data_reg;
      m_sat_next   = m_sat_reg;
      s_ready      = 1'b0;
      case (state_reg)
         ST_ACCUM: begin
            s_ready = 1'b1;
            if (s_valid) begin
               acc_next = ((cnt_reg == '0) ? bias_ext : acc_reg) + lane_sum;
               if (cnt_reg == LAST) begin
                  cnt_next   = '0;
                  state_next = ST_OUT;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         ST_OUT: begin
            if (!m_valid_reg) begin
               // Final accumulator is registered here, one edge after the last beat.
               m_valid_next = 1'b1;
               m_sat_next   = sat_res.clip;
`ifdef RELU_EN
               m_data_next  = sat_res.data[DATA_SIZE-1] ? '0 : sat_res.data;
`else
               m_data_next  = sat_res.data;
`endif
            end else if (m_ready) begin
               m_valid_next = 1'b0;
               state_next   = ST_ACCUM;
            end
         end
         default: state_next = ST_ACCUM;
      endcase
   end

   assign m_valid = m_valid_reg;
   assign m_data  = m_data_reg;
   assign m_sat   = m_sat_reg;

endmodule

// File: tb/tb_mac_accum_seq.sv
// Directed bench for mac_accum_seq: a TAPS=25 and a TAPS=23 instance run in lock-step
// (both need 5 beats) on shared inputs.
module tb_mac_accum_seq;

   logic        clk;
   logic        rst;
   logic        s_valid;
   logic        s_ready, s_ready23;
   logic [79:0] s_a, s_b;
   logic [15:0] s_bias;
   logic        m_valid, m_valid23;
   logic        m_ready;
   logic [15:0] m_data, m_data23;
   logic        m_sat, m_sat23;

   int pass_cnt  = 0;
   int total_cnt = 0;

`ifdef RELU_EN
   localparam logic [15:0] EXP_NEG    = 16'h0000;
   localparam logic [15:0] EXP_NEG23  = 16'h0000;
   localparam logic [15:0] EXP_SATN   = 16'h0000;
   localparam logic [15:0] EXP_FLOOR  = 16'h0000;
`else
   localparam logic [15:0] EXP_NEG    = 16'hE780;
   localparam logic [15:0] EXP_NEG23  = 16'hE980;
   localparam logic [15:0] EXP_SATN   = 16'h8000;
   localparam logic [15:0] EXP_FLOOR  = 16'hFFE7;
`endif

   mac_accum_seq dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .s_a(s_a), .s_b(s_b), .s_bias(s_bias),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_sat(m_sat)
   );

   mac_accum_seq #(.TAPS(23)) dut23 (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready23),
      .s_a(s_a), .s_b(s_b), .s_bias(s_bias),
      .m_valid(m_valid23), .m_ready(m_ready), .m_data(m_data23), .m_sat(m_sat23)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [79:0] rep5(input logic [15:0] w);
      return {5{w}};
   endfunction

   task automatic send_beat(input logic [79:0] a, input logic [79:0] b, input logic [15:0] bias);
      int n;
      n = 0;
      s_a = a; s_b = b; s_bias = bias; s_valid = 1'b1;
      while (!s_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!s_ready) begin
         total_cnt++;
         $display("FAIL beat_accept: s_ready=%b required 1 within 50 cycles", s_ready);
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      $display("beat a=%h b=%h bias=%h", a, b, bias);
   endtask

   task automatic send_window(input logic [15:0] a, input logic [15:0] b, input logic [15:0] bias);
      repeat (5) send_beat(rep5(a), rep5(b), bias);
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!m_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      if (!m_valid) begin
         total_cnt++;
         $display("FAIL result_timeout: m_valid=%b required 1 within 20 cycles", m_valid);
      end
      $display("result data=%h sat=%b data23=%h sat23=%b lat=%0d", m_data, m_sat, m_data23, m_sat23, lat);
   endtask

   task automatic handshake();
      m_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; m_ready = 1'b1;
      s_a = '0; s_b = '0; s_bias = '0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if ({m_valid, m_data, m_sat} !== 18'd0) $display("FAIL reset_out: got v=%b d=%h s=%b required 0/0000/0", m_valid, m_data, m_sat); else pass_cnt++;
      total_cnt++; if ({s_ready, s_ready23} !== 2'b11) $display("FAIL reset_ready: got %b required 11", {s_ready, s_ready23}); else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_unity();
      int lat;
      send_window(16'h0100, 16'h0100, 16'h0000);
      wait_valid(lat);
      total_cnt++; if (lat !== 1) $display("FAIL unity_latency: got %0d required 1", lat); else pass_cnt++;
      total_cnt++; if ({m_data, m_sat} !== {16'h1900, 1'b0}) $display("FAIL unity_data: got %h/%b required 1900/0", m_data, m_sat); else pass_cnt++;
      total_cnt++; if ({m_data23, m_sat23} !== {16'h1700, 1'b0}) $display("FAIL unity_data23: got %h/%b required 1700/0", m_data23, m_sat23); else pass_cnt++;
      total_cnt++; if (s_ready !== 1'b0) $display("FAIL unity_ready_out: got %b required 0", s_ready); else pass_cnt++;
      handshake();
      total_cnt++; if ({m_valid, s_ready} !== 2'b01) $display("FAIL unity_after_hs: got v=%b r=%b required 0/1", m_valid, s_ready); else pass_cnt++;
   endtask

   task automatic test_negative_bias();
      int lat;
      send_window(16'hFF00, 16'h0100, 16'h0080);
      wait_valid(lat);
      total_cnt++; if ({m_data, m_sat} !== {EXP_NEG, 1'b0}) $display("FAIL neg_data: got %h/%b required %h/0", m_data, m_sat, EXP_NEG); else pass_cnt++;
      total_cnt++; if (m_data23 !== EXP_NEG23) $display("FAIL neg_data23: got %h required %h", m_data23, EXP_NEG23); else pass_cnt++;
      handshake();
   endtask

   task automatic test_floor();
      int lat;
      // (-1/256)*(1/256) floors to -1 LSB per tap.
      send_window(16'hFFFF, 16'h0001, 16'h0000);
      wait_valid(lat);
      total_cnt++; if ({m_data, m_sat} !== {EXP_FLOOR, 1'b0}) $display("FAIL floor_data: got %h/%b required %h/0", m_data, m_sat, EXP_FLOOR); else pass_cnt++;
      handshake();
   endtask

   task automatic test_saturation();
      int lat;
      send_window(16'h7FFF, 16'h7FFF, 16'h0000);
      wait_valid(lat);
      total_cnt++; if ({m_data, m_sat} !== {16'h7FFF, 1'b1}) $display("FAIL sat_pos: got %h/%b required 7fff/1", m_data, m_sat); else pass_cnt++;
      total_cnt++; if ({m_data23, m_sat23} !== {16'h7FFF, 1'b1}) $display("FAIL sat_pos23: got %h/%b required 7fff/1", m_data23, m_sat23); else pass_cnt++;
      handshake();
      send_window(16'h8000, 16'h7FFF, 16'h0000);
      wait_valid(lat);
      total_cnt++; if ({m_data, m_sat} !== {EXP_SATN, 1'b1}) $display("FAIL sat_neg: got %h/%b required %h/1", m_data, m_sat, EXP_SATN); else pass_cnt++;
      handshake();
   endtask

   task automatic test_mask_backpressure();
      int lat;
      logic [15:0] held;
      m_ready = 1'b0;
      repeat (4) send_beat(rep5(16'h0100), rep5(16'h0100), 16'h0000);
      send_beat({16'h7FFF, 16'h7FFF, {3{16'h0100}}}, {16'h7FFF, 16'h7FFF, {3{16'h0100}}}, 16'h0000);
      wait_valid(lat);
      total_cnt++; if ({m_data23, m_sat23} !== {16'h1700, 1'b0}) $display("FAIL mask_data23: got %h/%b required 1700/0", m_data23, m_sat23); else pass_cnt++;
      total_cnt++; if ({m_data, m_sat} !== {16'h7FFF, 1'b1}) $display("FAIL mask_data25: got %h/%b required 7fff/1", m_data, m_sat); else pass_cnt++;
      held = m_data;
      s_a = rep5(16'h7FFF); s_b = rep5(16'h7FFF); s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total_cnt++; if ({m_valid, m_data23, m_data, s_ready} !== {1'b1, 16'h1700, held, 1'b0}) $display("FAIL hold_cycle%0d: got v=%b d23=%h d=%h r=%b required 1/1700/%h/0", i, m_valid, m_data23, m_data, s_ready, held); else pass_cnt++;
      end
      s_valid = 1'b0;
      handshake();
      total_cnt++; if ({m_valid, s_ready} !== 2'b01) $display("FAIL hold_release: got v=%b r=%b required 0/1", m_valid, s_ready); else pass_cnt++;
      send_window(16'h0100, 16'h0100, 16'h0000);
      wait_valid(lat);
      total_cnt++; if ({m_data, m_data23} !== {16'h1900, 16'h1700}) $display("FAIL hold_next_window: got %h/%h required 1900/1700", m_data, m_data23); else pass_cnt++;
      handshake();
   endtask

   task automatic test_stall();
      int lat;
      logic seen;
      repeat (2) send_beat(rep5(16'h0200), rep5(16'h0180), 16'h0000);
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         seen = seen | m_valid;
      end
      total_cnt++; if ({seen, s_ready} !== 2'b01) $display("FAIL stall_idle: got v=%b r=%b required 0/1", seen, s_ready); else pass_cnt++;
      repeat (3) send_beat(rep5(16'h0200), rep5(16'h0180), 16'h0000);
      wait_valid(lat);
      total_cnt++; if ({m_data, m_sat, m_data23} !== {16'h4B00, 1'b0, 16'h4500}) $display("FAIL stall_data: got %h/%b/%h required 4b00/0/4500", m_data, m_sat, m_data23); else pass_cnt++;
      handshake();
   endtask

   task automatic test_reset_mid();
      int lat;
      logic seen;
      // Asynchronous reset while a result is being held.
      m_ready = 1'b0;
      send_window(16'h0100, 16'h0100, 16'h0000);
      wait_valid(lat);
      #2 rst = 1'b1;
      #1;
      total_cnt++; if ({m_valid, m_data, m_sat, s_ready} !== {1'b0, 16'h0000, 1'b0, 1'b1}) $display("FAIL rst_in_out: got v=%b d=%h s=%b r=%b required 0/0000/0/1", m_valid, m_data, m_sat, s_ready); else pass_cnt++;
      @(posedge clk); #1 rst = 1'b0;
      m_ready = 1'b1;
      // Abort after three beats; a stale counter would misalign the next window.
      repeat (3) send_beat(rep5(16'h7FFF), rep5(16'h7FFF), 16'h1234);
      #2 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         seen = seen | m_valid;
      end
      total_cnt++; if (seen !== 1'b0) $display("FAIL rst_no_output: got m_valid=%b required 0", seen); else pass_cnt++;
      send_window(16'h0100, 16'h0100, 16'h0080);
      wait_valid(lat);
      total_cnt++; if ({m_data, m_data23, lat[3:0]} !== {16'h1980, 16'h1780, 4'd1}) $display("FAIL rst_fresh: got %h/%h lat=%0d required 1980/1780 lat=1", m_data, m_data23, lat); else pass_cnt++;
      handshake();
   endtask

   initial begin
      test_reset();
      test_unity();
      test_negative_bias();
      test_floor();
      test_saturation();
      test_mask_backpressure();
      test_stall();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
